// File: rtl/musa_pkg.sv
// musa_pkg: shared MUSA constants and the call-stack operation decode used by the stack and the control unit.
package musa_pkg;
  localparam int MUSA_PC_W = 18;
  typedef enum logic [1:0] {
    SOP_NOP  = 2'b00,
    SOP_PUSH = 2'b10,
    SOP_POP  = 2'b01,
    SOP_REPL = 2'b11
  } stack_op_t;
  function automatic stack_op_t decode_op(input logic push, input logic pop);
    return stack_op_t'({push, pop});
  endfunction
endpackage

// File: rtl/musa_call_stack_if.sv
// musa_call_stack_if: request/status bundle between the PC logic (master) and the return-address stack (slave).
interface musa_call_stack_if
  import musa_pkg::*;
#(
  parameter int ADDR_W = MUSA_PC_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              flush;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] push_addr;
  logic [ADDR_W-1:0] top_addr;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  modport master (
    output flush, push, pop, push_addr,
    input  top_addr, count, empty, full, overflow, underflow
  );
  modport slave (
    input  flush, push, pop, push_addr,
    output top_addr, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/musa_call_stack.sv
// musa_call_stack: parametrised return-address stack with flush, replace and overflow/underflow pulses.
// Define MUSA_STACK_WRAP_EN to make a push at full overwrite the oldest entry (circular stack).
module musa_call_stack
  import musa_pkg::*;
#(
  parameter int ADDR_W = MUSA_PC_W,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic               clk,
  input logic               rst_n,
  musa_call_stack_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  logic [ADDR_W-1:0] mem [DEPTH];
  idx_t              wp, wp_n, wa;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              we, ovf, unf, ovf_n, unf_n, is_full, is_empty;
  stack_op_t         op;

  // Explicit modulo so non-power-of-two depths wrap correctly.
  function automatic idx_t inc(input idx_t i);
    return (i == idx_t'(DEPTH - 1)) ? '0 : i + idx_t'(1);
  endfunction

  function automatic idx_t dec(input idx_t i);
    return (i == '0) ? idx_t'(DEPTH - 1) : i - idx_t'(1);
  endfunction

  assign op       = decode_op(bus.push, bus.pop);
  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == CNT_W'(DEPTH));

  always_comb begin
    wp_n  = wp;
    cnt_n = cnt;
    we    = 1'b0;
    wa    = wp;
    ovf_n = 1'b0;
    unf_n = 1'b0;
    if (!bus.flush) begin
      unique case (op)
        SOP_PUSH: begin
          if (!is_full) begin
            we    = 1'b1;
            wp_n  = inc(wp);
            cnt_n = cnt + CNT_W'(1);
          end else begin
            ovf_n = 1'b1;
`ifdef MUSA_STACK_WRAP_EN
            we    = 1'b1;
            wp_n  = inc(wp);
`endif
          end
        end
        SOP_POP: begin
          if (!is_empty) begin
            wp_n  = dec(wp);
            cnt_n = cnt - CNT_W'(1);
          end else begin
            unf_n = 1'b1;
          end
        end
        SOP_REPL: begin
          we = 1'b1;
          if (!is_empty) begin
            wa = dec(wp);
          end else begin
            wp_n  = inc(wp);
            cnt_n = cnt + CNT_W'(1);
            unf_n = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      wp_n  = '0;
      cnt_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (we) mem[wa] <= bus.push_addr;
      wp  <= wp_n;
      cnt <= cnt_n;
      ovf <= ovf_n;
      unf <= unf_n;
    end
  end

  assign bus.top_addr  = is_empty ? '0 : mem[dec(wp)];
  assign bus.count     = cnt;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
endmodule

// File: tb/tb_musa_call_stack.sv
// tb_musa_call_stack: table-driven check of the return-address stack at DEPTH=4, plus reset sequences.
module tb_musa_call_stack;
  localparam int AW = 18;
  localparam int DP = 4;
`ifdef MUSA_STACK_WRAP_EN
  localparam logic [AW-1:0] T0 = 18'h5, T1 = 18'h4, T2 = 18'h3, T3 = 18'h2;
`else
  localparam logic [AW-1:0] T0 = 18'h4, T1 = 18'h3, T2 = 18'h2, T3 = 18'h1;
`endif

  typedef struct {
    logic          fl, pu, po;
    logic [AW-1:0] addr;
    logic [2:0]    cnt;
    logic [AW-1:0] top;
    logic          emp, ful, ovf, unf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t tab [30];

  musa_call_stack_if #(.ADDR_W(AW), .DEPTH(DP)) bus ();
  musa_call_stack #(.ADDR_W(AW), .DEPTH(DP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input logic [2:0] c, input logic [AW-1:0] t,
                         input logic e, input logic f, input logic o, input logic u);
    chk("count", row, 32'(bus.count), 32'(c));
    chk("top_addr", row, 32'(bus.top_addr), 32'(t));
    chk("empty", row, 32'(bus.empty), 32'(e));
    chk("full", row, 32'(bus.full), 32'(f));
    chk("overflow", row, 32'(bus.overflow), 32'(o));
    chk("underflow", row, 32'(bus.underflow), 32'(u));
  endtask

  initial begin
    tab[0]  = '{0, 1, 0, 18'h10, 1, 18'h10, 0, 0, 0, 0};
    tab[1]  = '{0, 1, 0, 18'h20, 2, 18'h20, 0, 0, 0, 0};
    tab[2]  = '{0, 1, 0, 18'h30, 3, 18'h30, 0, 0, 0, 0};
    tab[3]  = '{0, 0, 1, 18'h0,  2, 18'h20, 0, 0, 0, 0};
    tab[4]  = '{0, 0, 1, 18'h0,  1, 18'h10, 0, 0, 0, 0};
    tab[5]  = '{0, 0, 1, 18'h0,  0, 18'h0,  1, 0, 0, 0};
    tab[6]  = '{0, 0, 1, 18'h0,  0, 18'h0,  1, 0, 0, 1};
    tab[7]  = '{0, 0, 0, 18'h0,  0, 18'h0,  1, 0, 0, 0};
    tab[8]  = '{0, 1, 0, 18'h1,  1, 18'h1,  0, 0, 0, 0};
    tab[9]  = '{0, 1, 0, 18'h2,  2, 18'h2,  0, 0, 0, 0};
    tab[10] = '{0, 1, 0, 18'h3,  3, 18'h3,  0, 0, 0, 0};
    tab[11] = '{0, 1, 0, 18'h4,  4, 18'h4,  0, 1, 0, 0};
    tab[12] = '{0, 1, 0, 18'h5,  4, T0,     0, 1, 1, 0};
    tab[13] = '{0, 0, 1, 18'h0,  3, T1,     0, 0, 0, 0};
    tab[14] = '{0, 0, 1, 18'h0,  2, T2,     0, 0, 0, 0};
    tab[15] = '{0, 0, 1, 18'h0,  1, T3,     0, 0, 0, 0};
    tab[16] = '{0, 0, 1, 18'h0,  0, 18'h0,  1, 0, 0, 0};
    tab[17] = '{0, 1, 0, 18'hA,  1, 18'hA,  0, 0, 0, 0};
    tab[18] = '{0, 1, 1, 18'hB,  1, 18'hB,  0, 0, 0, 0};
    tab[19] = '{0, 0, 1, 18'h0,  0, 18'h0,  1, 0, 0, 0};
    tab[20] = '{0, 1, 1, 18'hC,  1, 18'hC,  0, 0, 0, 1};
    tab[21] = '{0, 1, 0, 18'h11, 2, 18'h11, 0, 0, 0, 0};
    tab[22] = '{1, 1, 0, 18'h22, 0, 18'h0,  1, 0, 0, 0};
    tab[23] = '{0, 1, 0, 18'h1,  1, 18'h1,  0, 0, 0, 0};
    tab[24] = '{0, 1, 0, 18'h2,  2, 18'h2,  0, 0, 0, 0};
    tab[25] = '{0, 1, 0, 18'h3,  3, 18'h3,  0, 0, 0, 0};
    tab[26] = '{0, 1, 0, 18'h4,  4, 18'h4,  0, 1, 0, 0};
    tab[27] = '{0, 1, 1, 18'h9,  4, 18'h9,  0, 1, 0, 0};
    tab[28] = '{0, 0, 1, 18'h0,  3, 18'h3,  0, 0, 0, 0};
    tab[29] = '{1, 0, 1, 18'h0,  0, 18'h0,  1, 0, 0, 0};

    bus.flush = 1'b0;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.push_addr = '0;
    repeat (2) @(posedge clk);
    #1 chk_all(-1, 0, 0, 1, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.flush = tab[i].fl;
      bus.push = tab[i].pu;
      bus.pop = tab[i].po;
      bus.push_addr = tab[i].addr;
      @(posedge clk);
      #1 chk_all(i, tab[i].cnt, tab[i].top, tab[i].emp, tab[i].ful, tab[i].ovf, tab[i].unf);
    end

    // Reset asserted between edges while a push is pending must clear outputs without a clock.
    @(negedge clk);
    bus.flush = 1'b0;
    bus.pop = 1'b0;
    bus.push = 1'b1;
    bus.push_addr = 18'h5;
    @(posedge clk);
    #1 chk_all(100, 1, 18'h5, 0, 0, 0, 0);
    @(negedge clk);
    bus.push_addr = 18'h6;
    #2 rst_n = 1'b0;
    #1 chk_all(101, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    bus.push = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_all(102, 0, 0, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
